// File: rtl/fifo_defs.sv
// rtl/fifo_defs.sv - shared width and threshold defaults for the mux/fifo/demux data path
package fifo_defs;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_ADDR_WIDTH = 2;
    localparam int FIFO_AF_THRESH  = 3;
    localparam int FIFO_AE_THRESH  = 1;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, one write port and one registered read port
module fifo_mem
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array is deliberately left unreset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-edge write to rd_addr is not visible here, so a full push+pop returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - synchronous FIFO buffering the mux output stream for the downstream consumer
module fifo_buffer
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = FIFO_AF_THRESH,
    parameter int AE_THRESH  = FIFO_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT   = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT   = AE_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign fifo_count   = count;

    // A pop frees a slot in the same cycle, so push is allowed at full only alongside a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (reset_L),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed self-checking bench for fifo_buffer
module tb_fifo_buffer;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       push = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       pop = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    fifo_buffer dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cycle(input logic p, input logic [7:0] d, input logic q);
        push = p;
        data_in = d;
        pop = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic apply_reset();
        #2 reset_L = 1'b1;
        #3 reset_L = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 reset_L = 1'b1;
        #1;
        checks++;
        if ({fifo_count, empty, almost_empty, full, almost_full, valid_out, overflow, underflow}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: cnt=%0d e=%b ae=%b f=%b af=%b v=%b ov=%b un=%b required cnt=0 e=1 ae=1 f=0 af=0 v=0 ov=0 un=0",
                     fifo_count, empty, almost_empty, full, almost_full, valid_out, overflow, underflow);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: data_out=%h required 00", data_out);
        end
        #2 reset_L = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 8'hA0 + 8'(k), 1'b0);
            checks++;
            if ({fifo_count, empty, almost_empty, almost_full, full}
                !== {3'(k), 1'b0, (k <= 1), (k >= 3), (k == 4)}) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d e=%b ae=%b af=%b f=%b required cnt=%0d e=0 ae=%b af=%b f=%b",
                         k, fifo_count, empty, almost_empty, almost_full, full, k, (k <= 1), (k >= 3), (k == 4));
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if ({valid_out, data_out, fifo_count} !== {1'b1, 8'hA1 + 8'(k), 3'(3 - k)}) begin
                errors++;
                $display("FAIL drain_%0d: v=%b data=%h cnt=%0d required v=1 data=%h cnt=%0d",
                         k, valid_out, data_out, fifo_count, 8'hA1 + 8'(k), 3 - k);
            end
        end
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if ({valid_out, empty, data_out} !== {1'b0, 1'b1, 8'hA4}) begin
            errors++;
            $display("FAIL drain_end: v=%b e=%b data=%h required v=0 e=1 data=a4", valid_out, empty, data_out);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 1; k <= 4; k++) cycle(1'b1, 8'hA0 + 8'(k), 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        checks++;
        if ({fifo_count, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overflow_set: cnt=%0d f=%b ov=%b required cnt=4 f=1 ov=1", fifo_count, full, overflow);
        end
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ov=%b required 1", overflow);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if ({valid_out, data_out} !== {1'b1, 8'hA1 + 8'(k)}) begin
                errors++;
                $display("FAIL overflow_drain_%0d: v=%b data=%h required v=1 data=%h",
                         k, valid_out, data_out, 8'hA1 + 8'(k));
            end
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({valid_out, empty, underflow, overflow} !== {1'b0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overflow_empty: v=%b e=%b un=%b ov=%b required v=0 e=1 un=1 ov=1",
                     valid_out, empty, underflow, overflow);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h11;
        exp_seq[1] = 8'h12;
        exp_seq[2] = 8'h13;
        exp_seq[3] = 8'h20;
        apply_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'h10 + 8'(k), 1'b0);
        cycle(1'b1, 8'h20, 1'b1);
        checks++;
        if ({valid_out, data_out, fifo_count, full, overflow} !== {1'b1, 8'h10, 3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul_full: v=%b data=%h cnt=%0d f=%b ov=%b required v=1 data=10 cnt=4 f=1 ov=0",
                     valid_out, data_out, fifo_count, full, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if ({valid_out, data_out} !== {1'b1, exp_seq[k]}) begin
                errors++;
                $display("FAIL simul_drain_%0d: v=%b data=%h required v=1 data=%h",
                         k, valid_out, data_out, exp_seq[k]);
            end
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({underflow, valid_out, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL underflow_pop: un=%b v=%b cnt=%0d required un=1 v=0 cnt=0", underflow, valid_out, fifo_count);
        end
        cycle(1'b1, 8'h77, 1'b1);
        checks++;
        if ({fifo_count, valid_out, empty} !== {3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL empty_push_pop: cnt=%0d v=%b e=%b required cnt=1 v=0 e=0", fifo_count, valid_out, empty);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({valid_out, data_out, fifo_count} !== {1'b1, 8'h77, 3'd0}) begin
            errors++;
            $display("FAIL empty_followup: v=%b data=%h cnt=%0d required v=1 data=77 cnt=0", valid_out, data_out, fifo_count);
        end
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        cycle(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cycle((k < 10), 8'(k), 1'b1);
            checks++;
            if ({valid_out, data_out} !== {1'b1, 8'(k - 1)}) begin
                errors++;
                $display("FAIL wrap_%0d: v=%b data=%h required v=1 data=%h", k - 1, valid_out, data_out, 8'(k - 1));
            end
        end
        cycle(1'b1, 8'hE1, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0);
        cycle(1'b1, 8'hE3, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({valid_out, data_out, fifo_count} !== {1'b1, 8'hE1, 3'd2}) begin
            errors++;
            $display("FAIL midop_pre: v=%b data=%h cnt=%0d required v=1 data=e1 cnt=2", valid_out, data_out, fifo_count);
        end
        #2 reset_L = 1'b1;
        #1;
        checks++;
        if ({valid_out, data_out, fifo_count, empty, almost_empty, full, almost_full}
            !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: v=%b data=%h cnt=%0d e=%b ae=%b f=%b af=%b required v=0 data=00 cnt=0 e=1 ae=1 f=0 af=0",
                     valid_out, data_out, fifo_count, empty, almost_empty, full, almost_full);
        end
        #3 reset_L = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({valid_out, data_out, fifo_count, underflow} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL midop_after: v=%b data=%h cnt=%0d un=%b required v=0 data=00 cnt=0 un=1",
                     valid_out, data_out, fifo_count, underflow);
        end
    endtask

    initial begin
        reset_L = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_L = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_underflow();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Parameterised synchronous FIFO directly downstream of the 2:1 mux stage.
- Accepts the mux's data_out/valid_out stream as push data and buffers it for the next consumer (demux/serialiser).
- The consumer drains it with pop.
- Provides occupancy flags, almost-full/almost-empty thresholds for upstream flow control, and sticky overflow/underflow error bits.

Parameters:
- DATA_WIDTH, 8, width of each stored word; matches the mux data path.
- DEPTH, 4, number of entries; must be a power of 2.
- ADDR_WIDTH, 2, log2(DEPTH).
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous, active-high reset (1 = reset asserted).
- push  in  1  write request; connected to mux valid_out.
- data_in  in  DATA_WIDTH  write data; connected to mux data_out.
- pop  in  1  read request from the consumer.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out is valid for this cycle (one-cycle pulse per accepted pop).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected while full.
- underflow  out  1  sticky: a pop was rejected while empty.

Behaviour:
- Reset (asynchronous on reset_L rising; held while reset_L=1):
  - wr_ptr, rd_ptr, count, data_out, valid_out, overflow and underflow all go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are don't-care.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 naturally; no extra wrap logic.
- Accepted push: push=1 and (not full, or pop accepted in the same cycle).
  - Writes data_in at wr_ptr and increments wr_ptr.
- Accepted pop: pop=1 and not empty.
  - On the next rising edge, data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr increments.
  - Read latency is 1 cycle from pop to valid_out.
- No accepted pop: valid_out <= 0 and data_out holds its last value.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
- Simultaneous push+pop while full: both accepted; count stays at DEPTH. The popped word is the oldest entry, and the new word is written into the freed slot.
- Simultaneous push+pop while empty: only the push is accepted, count becomes 1, and there is no bypass. The pop is rejected and sets underflow.
- Push while full without a pop: word dropped, overflow <= 1 (sticky until reset), count and pointers unchanged.
- Pop while empty: underflow <= 1 (sticky), valid_out <= 0.
- Flags (full, empty, almost_full, almost_empty) are decoded combinationally from the registered count. They therefore reflect the state after the last edge and add no extra latency.
- Reset mid-operation: all state clears immediately and asynchronously. Any in-flight pop result is lost and valid_out drops to 0 without waiting for a clock.
- No X propagation: data_out is never driven from an unwritten location, because pops are gated by empty.

Decomposition:
- Shared package/header `fifo_defs`:
  - DATA_WIDTH, DEPTH and ADDR_WIDTH defaults.
  - Threshold defaults, so the mux, FIFO and downstream demux agree on widths.
- Sub-module `fifo_mem`:
  - DEPTH x DATA_WIDTH register array with one write port (wr_en, wr_addr, wr_data) and one registered read port (rd_en, rd_addr, rd_data).
  - Pointer/count/flag control stays in fifo_buffer.

Test Plan:
- Reset check: assert reset_L=1 mid-cycle → immediately count=0, empty=1, almost_empty=1, full=0, valid_out=0, data_out=0x00, overflow=underflow=0.
- Fill and drain:
  - Push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → count 1,2,3,4. almost_empty deasserts at count 2, almost_full asserts at 3, full at 4.
  - Then pop 4 times → valid_out pulses one cycle after each pop with data 0xA1..0xA4 in order; empty=1 at the end.
- Overflow: from full, push 0x55 → count stays 4, overflow=1 and stays 1. A later drain returns 0xA1..0xA4 only; 0x55 never appears.
- Simultaneous at full: from full (0x10..0x13), push 0x20 with pop in the same cycle → data_out=0x10, count stays 4. A subsequent drain yields 0x11, 0x12, 0x13, 0x20.
- Underflow/empty corner:
  - pop on empty → underflow=1, valid_out=0.
  - push 0x77 with pop in the same cycle on empty → count=1, valid_out=0.
  - Next pop → data_out=0x77, valid_out=1.
- Wrap-around and mid-op reset:
  - Run 10 push/pop pairs with values 0x00..0x09 → output order preserved across pointer wrap.
  - Then assert reset with count=2 → flags return to reset values and the stale data is not output.
